// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: one shared digit slice walks the operands LSD first.
// Optional invalid-digit flag is built when BCD_DIGIT_CHECK_EN is defined; otherwise err is tied low.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CW-1:0]         cnt_r;
    logic                  carry_r;
    logic                  cout_r;
    logic [4*DIGITS-1:0]   a_r;
    logic [4*DIGITS-1:0]   b_r;
    logic [4*DIGITS-1:0]   sum_r;
    logic [CW+1:0]         idx_s;
    logic [4:0]            slice_s;

    // Single-digit BCD slice: {carry, digit}; values above 9 are corrected by +6 mod 16.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] t;
        logic [4:0] adj;
        t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        adj = t + 5'd6;
        if (t > 5'd9) begin
            digit_add = {1'b1, adj[3:0]};
        end else begin
            digit_add = {1'b0, t[3:0]};
        end
    endfunction

`ifdef BCD_DIGIT_CHECK_EN
    logic err_r;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic f;
        f = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                f = 1'b1;
            end
        end
        has_bad_digit = f;
    endfunction

    // Flag captured at accept time and held until the next accept or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_r == IDLE && in_valid) begin
            err_r <= has_bad_digit(a) | has_bad_digit(b);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Current digit selection feeding the shared slice.
    always_comb begin
        idx_s   = {cnt_r, 2'b00};
        slice_s = digit_add(a_r[idx_s +: 4], b_r[idx_s +: 4], carry_r);
    end

    // Operand capture and per-digit accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx_s +: 4] <= slice_s[3:0];
                    carry_r           <= slice_s[4];
                    cnt_r             <= cnt_r + ONE;
                    if (cnt_r == LAST) begin
                        cout_r <= slice_s[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: driver pushes expected results, a negedge monitor pops and compares.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;
`ifdef BCD_DIGIT_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on rising out_valid, stability while held, scoreboard pop on handshake.
    logic         prev_valid = 1'b0;
    logic [W-1:0] held_sum;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                check("latency", 64'(cyc - sb[0].acc), 64'(DIGITS));
            end
            held_sum = sum;
        end else if (out_valid === 1'b1) begin
            check("hold_sum", sum, held_sum);
            check("hold_in_ready", in_ready, 64'd0);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_accept", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("err", err, e.err);
            end
        end
        prev_valid = (out_valid === 1'b1);
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic ee,
                        input bit keep, input bit push);
        int n;
        bit acc;
        exp_t e;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = av;
            b = bv;
            cin = ci;
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                last_acc = cyc;
                if (push) begin
                    e.sum = es; e.cout = ec; e.err = ee; e.acc = cyc;
                    sb.push_back(e);
                end
                if (!keep) in_valid = 1'b0;
            end
            n++;
        end
        if (!acc) check("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n;
        int first;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 64'd1);
        check("rst_out_valid", out_valid, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", cout, 64'd0);
        check("rst_err", err, 64'd0);

        send(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h000F, 16'h000F, 1'b1, 16'h0015, 1'b0, CHK, 1'b0, 1'b1);
        drain();

        // Backpressure: result held for 6 cycles with out_ready low.
        out_ready = 1'b0;
        send(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("bp_valid_held", out_valid, 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", in_ready, 64'd1);
        check("bp_out_valid_after", out_valid, 64'd0);
        check("bp_popped", 64'(sb.size()), 64'd0);

        // Reset after two digits: operation discarded.
        send(16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 64'd1);
        check("mid_rst_out_valid", out_valid, 64'd0);
        check("mid_rst_sum", sum, 64'd0);
        check("mid_rst_cout", cout, 64'd0);
        send(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-to-back with in_valid held high.
        send(16'h2468, 16'h1357, 1'b0, 16'h3825, 1'b0, 1'b0, 1'b1, 1'b1);
        first = last_acc;
        send(16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        check("b2b_gap", 64'(last_acc - first), 64'(DIGITS + 2));
        drain();

        send(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, CHK, 1'b0, 1'b1);
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
